// File: rtl/fp_solver_axil_pkg.sv
// Shared constants and state types for the solver AXI4-Lite register bank.
package fp_solver_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Word indices of the fixed registers; operands start at OPS_BASE.
   localparam int unsigned CTRL_IDX   = 0;
   localparam int unsigned STATUS_IDX = 1;
   localparam int unsigned OPS_BASE   = 2;

   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_IRQ_EN_BIT = 1;

   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;
   localparam int unsigned STAT_ERR_BIT  = 2;

   typedef enum logic [1:0] {
      W_IDLE,
      W_EXEC,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-strobe merge: each byte lane takes the new word where its strobe is set.
module axil_strb_merge #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_word,
   input  logic [DATA_WIDTH-1:0]   new_word,
   input  logic [DATA_WIDTH/8-1:0] strb,
   output logic [DATA_WIDTH-1:0]   merged
);

   // Per-lane select between the stored and written bytes.
   always_comb begin
      merged = old_word;
      for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
         if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
   end

endmodule

// File: rtl/fp_solver_axil_regs.sv
// AXI4-Lite register bank fronting the floating-point solver core:
// CTRL/STATUS, operand (RW) and result (RO) registers, start/done handshake, irq.
module fp_solver_axil_regs
   import fp_solver_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned NUM_OPS    = 3,
   parameter int unsigned NUM_RES    = 2
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]         S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic                          start_o,
   output logic [NUM_OPS*DATA_WIDTH-1:0] operand_o,
   input  logic                          done_i,
   input  logic [NUM_RES*DATA_WIDTH-1:0] result_i,
   output logic                          irq_o
);

   localparam int unsigned STRB_W   = DATA_WIDTH/8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned RES_BASE = OPS_BASE + NUM_OPS;
   localparam int unsigned NUM_REGS = RES_BASE + NUM_RES;

   // Register state
   logic                  irq_en_q, busy_q, done_q, err_q, start_q, irq_q;
   logic [DATA_WIDTH-1:0] ops_q [NUM_OPS];
   logic [DATA_WIDTH-1:0] res_q [NUM_RES];
   logic                  irq_en_d, busy_d, done_d, err_d, start_ok;
   logic [DATA_WIDTH-1:0] ops_d [NUM_OPS];
   logic [DATA_WIDTH-1:0] res_d [NUM_RES];

   // Write channel
   wr_state_t             w_state, w_state_d;
   logic                  aw_held_q, w_held_q, aw_held_d, w_held_d;
   logic                  aw_ready_q, w_ready_q, aw_ready_d, w_ready_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [STRB_W-1:0]     wr_strb_q;
   logic [1:0]            bresp_q;
   logic                  aw_hs, w_hs, w_exec;
   logic [31:0]           w_idx;

   // Read channel
   rd_state_t             r_state, r_state_d;
   logic                  ar_ready_q;
   logic                  ar_hs;
   logic [31:0]           rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_decerr;

   // Strobe-merged candidate values for the writable registers
   logic [DATA_WIDTH-1:0] ctrl_word, ctrl_merged;
   logic [DATA_WIDTH-1:0] ops_merged [NUM_OPS];

   assign aw_hs  = S_AXI_AWVALID & aw_ready_q;
   assign w_hs   = S_AXI_WVALID & w_ready_q;
   assign ar_hs  = S_AXI_ARVALID & ar_ready_q;
   assign w_exec = (w_state == W_EXEC);
   assign w_idx  = 32'(wr_addr_q[ADDR_WIDTH-1:ADDR_LSB]);
   assign rd_idx = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

   assign S_AXI_AWREADY = aw_ready_q;
   assign S_AXI_WREADY  = w_ready_q;
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = ar_ready_q;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign start_o       = start_q;
   assign irq_o         = irq_q;

   // START is never stored, so the CTRL image only carries IRQ_EN.
   always_comb begin
      ctrl_word                  = '0;
      ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
   end

   axil_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl_merge (
      .old_word (ctrl_word),
      .new_word (wr_data_q),
      .strb     (wr_strb_q),
      .merged   (ctrl_merged)
   );

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops
      axil_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_op_merge (
         .old_word (ops_q[k]),
         .new_word (wr_data_q),
         .strb     (wr_strb_q),
         .merged   (ops_merged[k])
      );
      assign operand_o[k*DATA_WIDTH +: DATA_WIDTH] = ops_q[k];
   end

   // Write FSM next state; AW and W are latched independently in W_IDLE.
   always_comb begin
      w_state_d = w_state;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs)  w_held_d  = 1'b1;
            if (aw_held_d && w_held_d) w_state_d = W_EXEC;
         end
         W_EXEC: w_state_d = W_RESP;
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_IDLE;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      // Ready is registered so it is low throughout reset.
      aw_ready_d = (w_state_d == W_IDLE) && !aw_held_d;
      w_ready_d  = (w_state_d == W_IDLE) && !w_held_d;
   end

   // Write FSM state, channel latches and response code.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state    <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         bresp_q    <= RESP_OKAY;
      end else begin
         w_state    <= w_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         if (aw_hs) wr_addr_q <= S_AXI_AWADDR;
         if (w_hs) begin
            wr_data_q <= S_AXI_WDATA;
            wr_strb_q <= S_AXI_WSTRB;
         end
         if (w_exec) bresp_q <= (w_idx < NUM_REGS) ? RESP_OKAY : RESP_DECERR;
      end
   end

   // Register next state: W1C clears apply first so set events win.
   always_comb begin
      logic start_req;
      logic stat_wr;
      start_req = w_exec && (w_idx == CTRL_IDX) && ctrl_merged[CTRL_START_BIT];
      stat_wr   = w_exec && (w_idx == STATUS_IDX) && wr_strb_q[0];
      start_ok  = start_req && !busy_q;

      irq_en_d = irq_en_q;
      if (w_exec && (w_idx == CTRL_IDX)) irq_en_d = ctrl_merged[CTRL_IRQ_EN_BIT];

      busy_d = busy_q;
      if (done_i)   busy_d = 1'b0;
      if (start_ok) busy_d = 1'b1;

      done_d = done_q;
      if (stat_wr && wr_data_q[STAT_DONE_BIT]) done_d = 1'b0;
      if (done_i) done_d = 1'b1;

      err_d = err_q;
      if (stat_wr && wr_data_q[STAT_ERR_BIT]) err_d = 1'b0;
      if (start_req && busy_q) err_d = 1'b1;

      for (int unsigned k = 0; k < NUM_OPS; k++) begin
         ops_d[k] = ops_q[k];
         if (w_exec && (w_idx == OPS_BASE + k)) ops_d[k] = ops_merged[k];
      end
      for (int unsigned r = 0; r < NUM_RES; r++) begin
         res_d[r] = done_i ? result_i[r*DATA_WIDTH +: DATA_WIDTH] : res_q[r];
      end
   end

   // Register bank, start pulse and interrupt.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         irq_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         irq_q    <= 1'b0;
         ops_q    <= '{default: '0};
         res_q    <= '{default: '0};
      end else begin
         irq_en_q <= irq_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         start_q  <= start_ok;
         irq_q    <= done_q & irq_en_q;
         ops_q    <= ops_d;
         res_q    <= res_d;
      end
   end

   // Read mux looks at next-state values so a write committing on the AR edge is seen.
   always_comb begin
      rd_word   = '0;
      rd_decerr = 1'b0;
      if (rd_idx == CTRL_IDX) begin
         rd_word[CTRL_IRQ_EN_BIT] = irq_en_d;
      end else if (rd_idx == STATUS_IDX) begin
         rd_word[STAT_BUSY_BIT] = busy_d;
         rd_word[STAT_DONE_BIT] = done_d;
         rd_word[STAT_ERR_BIT]  = err_d;
      end else if (rd_idx >= NUM_REGS) begin
         rd_decerr = 1'b1;
      end
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
         if (rd_idx == OPS_BASE + k) rd_word = ops_d[k];
      end
      for (int unsigned r = 0; r < NUM_RES; r++) begin
         if (rd_idx == RES_BASE + r) rd_word = res_d[r];
      end
   end

   // Read FSM next state.
   always_comb begin
      r_state_d = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM state with RDATA/RRESP captured at the AR handshake.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state     <= R_IDLE;
         ar_ready_q  <= 1'b0;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
      end else begin
         r_state    <= r_state_d;
         ar_ready_q <= (r_state_d == R_IDLE);
         if (ar_hs) begin
            S_AXI_RDATA <= rd_word;
            S_AXI_RRESP <= rd_decerr ? RESP_DECERR : RESP_OKAY;
         end
      end
   end

   logic unused;
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr_q[ADDR_LSB-1:0],
                     S_AXI_ARADDR[ADDR_LSB-1:0], ctrl_merged};

endmodule
